// File: rtl/dcache_lsu.sv
// Load/store unit: turns byte-addressed byte/halfword/word requests into
// word-indexed cache accesses, with read-modify-write for sub-word stores.
module dcache_lsu #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              ready_o,
    output logic              misalign_o,
    output logic              busy_o,
    output logic [ADDR_W-3:0] cache_addr_o,
    output logic [31:0]       cache_dato_o,
    output logic              cache_memwrite_o,
    output logic              cache_memread_o,
    input  logic [31:0]       cache_dato_i
);

    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR} state_t;

    state_t      state;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic [31:0] merged_q;

    logic        misalign;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_v;
    logic [31:0] merge_v;

    assign misalign = (size_i == 2'b11) ||
                      (size_i == 2'b01 && addr_i[0]) ||
                      (size_i == 2'b10 && addr_i[1:0] != 2'b00);

    assign byte_v = cache_dato_i[{lane_q, 3'b000} +: 8];
    assign half_v = cache_dato_i[{lane_q[1], 4'b0000} +: 16];

    always_comb begin
        case (size_q)
            2'b00:   load_v = {{24{~uns_q & byte_v[7]}}, byte_v};
            2'b01:   load_v = {{16{~uns_q & half_v[15]}}, half_v};
            default: load_v = cache_dato_i;
        endcase
    end

    always_comb begin
        merge_v = cache_dato_i;
        if (size_q == 2'b00)
            merge_v[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merge_v[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    // Strobes are qualified by reset so a reset landing mid-RMW never writes.
    assign cache_memread_o  = !rst_i && (state == RD || state == RMW_RD);
    assign cache_memwrite_o = !rst_i && (state == WR || state == RMW_WR);

    always_comb begin
        cache_dato_o = 32'd0;
        if (!rst_i) begin
            if (state == WR)
                cache_dato_o = wdata_q;
            else if (state == RMW_WR)
                cache_dato_o = merged_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= 32'd0;
            merged_q     <= 32'd0;
            rdata_o      <= 32'd0;
            ready_o      <= 1'b0;
            misalign_o   <= 1'b0;
            busy_o       <= 1'b0;
            cache_addr_o <= '0;
        end else begin
            ready_o    <= 1'b0;
            misalign_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        size_q  <= size_i;
                        uns_q   <= unsigned_i;
                        lane_q  <= addr_i[1:0];
                        wdata_q <= wdata_i;
                        if (misalign) begin
                            ready_o    <= 1'b1;
                            misalign_o <= 1'b1;
                        end else begin
                            busy_o       <= 1'b1;
                            cache_addr_o <= addr_i[ADDR_W-1:2];
                            if (!we_i)
                                state <= RD;
                            else if (size_i == 2'b10)
                                state <= WR;
                            else
                                state <= RMW_RD;
                        end
                    end
                end
                RD: begin
                    rdata_o <= load_v;
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end
                RMW_RD: begin
                    merged_q <= merge_v;
                    state    <= RMW_WR;
                end
                WR, RMW_WR: begin
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_lsu.sv
// Directed bench for dcache_lsu with a 64-word behavioural cache.
module tb_dcache_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ready, misalign, busy;
    logic [5:0]  c_addr;
    logic [31:0] c_dato_o, c_dato_i;
    logic        c_we, c_re;

    logic [31:0] mem [64];
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dcache_lsu #(.ADDR_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .size_i(size),
        .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata),
        .ready_o(ready), .misalign_o(misalign), .busy_o(busy),
        .cache_addr_o(c_addr), .cache_dato_o(c_dato_o),
        .cache_memwrite_o(c_we), .cache_memread_o(c_re),
        .cache_dato_i(c_dato_i)
    );

    assign c_dato_i = mem[c_addr];
    always @(posedge clk) if (c_we) mem[c_addr] <= c_dato_o;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [1:0] s, input logic u,
                         input logic [7:0] a, input logic [31:0] d);
        we = w; size = s; uns = u; addr = a; wdata = d; req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    // Called right after the accepting edge; checks cycles until ready_o.
    task automatic wait_ready(input string tag, input int lat);
        int n = 1;
        while (!ready && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, lat);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        tick(); tick();
        chk("rst_rdata", rdata, 0);
        chk("rst_flags", {ready, misalign, busy, c_we, c_re}, 0);
        chk("rst_caddr", c_addr, 0);
        chk("rst_dato", c_dato_o, 0);
        rst = 1'b0;
        tick();

        // word store then word load
        issue(1, 2'b10, 0, 8'h10, 32'hDEADBEEF);
        chk("wr_state", {busy, c_we, c_re}, 3'b110);
        chk("wr_addr", c_addr, 4);
        chk("wr_dato", c_dato_o, 32'hDEADBEEF);
        wait_ready("wr", 2);
        chk("wr_idle", {busy, c_we, c_re, misalign}, 0);
        chk("wr_mem", mem[4], 32'hDEADBEEF);
        tick();
        issue(0, 2'b10, 0, 8'h10, 32'd0);
        chk("rd_state", {busy, c_we, c_re}, 3'b101);
        wait_ready("rd", 2);
        chk("rd_data", rdata, 32'hDEADBEEF);

        // byte store lane 1 via read-modify-write
        issue(1, 2'b00, 0, 8'h11, 32'h000000AA);
        chk("rmw_rd", {busy, c_we, c_re}, 3'b101);
        tick();
        chk("rmw_wr", {busy, c_we, c_re}, 3'b110);
        chk("rmw_dato", c_dato_o, 32'hDEADAAEF);
        tick();
        chk("rmw_lat", ready, 1);
        chk("rmw_mem", mem[4], 32'hDEADAAEF);

        // sub-word loads
        issue(0, 2'b00, 0, 8'h11, 0); wait_ready("lb", 2);
        chk("lb_s", rdata, 32'hFFFFFFAA);
        issue(0, 2'b00, 1, 8'h11, 0); wait_ready("lbu", 2);
        chk("lb_u", rdata, 32'h000000AA);
        issue(0, 2'b01, 0, 8'h12, 0); wait_ready("lh", 2);
        chk("lh_s", rdata, 32'hFFFFDEAD);
        issue(0, 2'b00, 0, 8'h13, 0); wait_ready("lb3", 2);
        chk("lb3_s", rdata, 32'hFFFFFFDE);
        issue(0, 2'b01, 1, 8'h10, 0); wait_ready("lhu", 2);
        chk("lh_u", rdata, 32'h0000AAEF);

        // misaligned requests
        issue(0, 2'b10, 0, 8'h13, 0);
        chk("mis_w", {ready, misalign, busy, c_we, c_re}, 5'b11000);
        chk("mis_w_rdata", rdata, 32'h0000AAEF);
        chk("mis_w_caddr", c_addr, 4);
        issue(1, 2'b01, 0, 8'h05, 32'h0000BEEF);
        chk("mis_h", {ready, misalign, busy, c_we, c_re}, 5'b11000);
        tick();
        chk("mis_h_clr", {ready, misalign}, 0);
        chk("mis_h_mem", mem[1], 0);
        issue(0, 2'b11, 0, 8'h10, 0);
        chk("mis_sz3", {ready, misalign, busy}, 3'b110);
        chk("mis_sz3_rdata", rdata, 32'h0000AAEF);

        // req held through busy, new request in the ready cycle
        we = 0; size = 2'b10; uns = 0; addr = 8'h10; req = 1'b1;
        tick();
        chk("hold_busy", {busy, c_re}, 2'b11);
        tick();
        chk("hold_ready", {ready, busy, c_re}, 3'b100);
        chk("hold_rdata", rdata, 32'hDEADAAEF);
        we = 1; size = 2'b10; addr = 8'h20; wdata = 32'h12345678;
        tick();
        req = 1'b0;
        chk("b2b_wr", {ready, busy, c_we}, 3'b011);
        chk("b2b_addr", c_addr, 8);
        tick();
        chk("b2b_ready", ready, 1);
        chk("b2b_mem", mem[8], 32'h12345678);

        // reset during RMW_WR
        issue(1, 2'b00, 0, 8'h20, 32'h00000055);
        tick();
        rst = 1'b1;
        #1;
        chk("rstrmw_we", c_we, 0);
        tick();
        chk("rstrmw_out", {ready, misalign, busy, c_we, c_re}, 0);
        chk("rstrmw_data", {c_dato_o, rdata}, 0);
        rst = 1'b0;
        tick();
        chk("rstrmw_noready", ready, 0);
        chk("rstrmw_mem", mem[8], 32'h12345678);
        issue(0, 2'b10, 0, 8'h20, 0); wait_ready("rb", 2);
        chk("rstrmw_rb", rdata, 32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
